// File: rtl/pulp_cluster_package.sv
`default_nettype none
// ============================================================================
//  Module   : pulp_cluster_package
//  Brief    : Shared core data-port request/response types and defaults.
//  Revision : 1.0
// ============================================================================
package pulp_cluster_package;

    localparam logic [31:0] CORE_DATA_ERR_DATA_DEFAULT = 32'hBADC_AB1E;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic [31:0] r_data;
        logic        r_valid;
    } core_data_rsp_t;

endpackage
`default_nettype wire

// File: rtl/core_data_responder_mem.sv
`default_nettype none
// ============================================================================
//  Module   : core_data_responder_mem
//  Brief    : Single-port word storage, per-byte write enables, registered read.
//  Revision : 1.0
// ============================================================================
module core_data_responder_mem #(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_be,
    output logic [31:0]       o_rdata
);

    // One bank per byte lane so each lane has its own independent write enable.
    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [7:0] r_bank [NUM_WORDS];
        logic [7:0] r_rd_byte;

        always_ff @(posedge clk) begin
            if (i_en) begin
                if (i_we && i_be[b]) begin
                    r_bank[i_addr] <= i_wdata[8*b +: 8];
                end
                r_rd_byte <= r_bank[i_addr];
            end
        end

        assign o_rdata[8*b +: 8] = r_rd_byte;
    end

endmodule
`default_nettype wire

// File: rtl/core_data_responder.sv
`default_nettype none
// ============================================================================
//  Module   : core_data_responder
//  Brief    : Core data-port slave with configurable grant delay over local RAM.
//  Revision : 1.0
// ============================================================================
module core_data_responder
    import pulp_cluster_package::*;
#(
    parameter int unsigned NumWords   = 256,
    parameter int unsigned WaitCycles = 0,
    parameter logic [31:0] BaseAddr   = 32'h1000_0000,
    parameter logic [31:0] ErrData    = CORE_DATA_ERR_DATA_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  core_data_req_t req_i,
    output core_data_rsp_t rsp_o,
    output logic           err_o,
    output logic           busy_o
);

    localparam int unsigned c_addr_w = $clog2(NumWords);
    localparam logic [31:0] c_span   = 32'(NumWords * 4);
    localparam logic [3:0]  c_wait   = 4'(WaitCycles);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_valid;
    logic        r_err;
    logic        r_is_write;
    logic [31:0] r_hold;

    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_gnt;
    logic        w_hs;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_resp_data;

    // Below-base addresses wrap to huge offsets, so one compare covers both bounds.
    assign w_offset   = req_i.add - BaseAddr;
    assign w_in_range = (w_offset < c_span);

    always_comb begin
        w_gnt = 1'b0;
        if (req_i.req && !rst_i) begin
            if (WaitCycles == 0) begin
                w_gnt = (r_state != ST_WAIT);
            end else begin
                w_gnt = (r_state == ST_WAIT) && (r_cnt == c_wait);
            end
        end
    end

    assign w_hs = req_i.req & w_gnt;

    core_data_responder_mem #(
        .NUM_WORDS (NumWords),
        .ADDR_W    (c_addr_w)
    ) u_mem (
        .clk     (clk_i),
        .i_en    (w_hs & w_in_range),
        .i_we    (req_i.we),
        .i_addr  (w_offset[c_addr_w+1:2]),
        .i_wdata (req_i.data),
        .i_be    (req_i.be),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_is_write <= 1'b0;
            r_hold     <= 32'h0;
        end else begin
            r_valid <= w_hs;
            r_err   <= w_hs & ~w_in_range;
            if (w_hs) begin
                r_is_write <= req_i.we;
            end
            if (r_valid) begin
                r_hold <= w_resp_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_i.req) begin
                        if (WaitCycles == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_i.req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == c_wait) begin
                        r_state <= ST_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!req_i.req) begin
                        r_state <= ST_IDLE;
                    end else if (WaitCycles == 0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign w_resp_data = r_is_write ? 32'h0 : (r_err ? ErrData : w_mem_rdata);

    always_comb begin
        rsp_o         = '0;
        rsp_o.gnt     = w_gnt;
        rsp_o.r_valid = r_valid;
        rsp_o.r_data  = r_valid ? w_resp_data : r_hold;
    end

    assign err_o  = r_err;
    assign busy_o = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_data_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_data_responder
//  Brief    : Directed self-checking bench for zero-wait and three-wait responders.
//  Revision : 1.0
// ============================================================================
module tb_core_data_responder;
    import pulp_cluster_package::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    core_data_req_t req0;
    core_data_req_t req3;
    core_data_rsp_t rsp0;
    core_data_rsp_t rsp3;
    logic           err0;
    logic           err3;
    logic           busy0;
    logic           busy3;
    int             n_cmp  = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    core_data_responder #(.WaitCycles(0)) dut0 (
        .clk_i (clk), .rst_i (rst), .req_i (req0), .rsp_o (rsp0), .err_o (err0), .busy_o (busy0)
    );

    core_data_responder #(.WaitCycles(3)) dut3 (
        .clk_i (clk), .rst_i (rst), .req_i (req3), .rsp_o (rsp3), .err_o (err3), .busy_o (busy3)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drv0(input logic r, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] b);
        req0.req = r; req0.add = a; req0.we = w; req0.data = d; req0.be = b;
    endtask

    task automatic drv3(input logic r, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] b);
        req3.req = r; req3.add = a; req3.we = w; req3.data = d; req3.be = b;
    endtask

    initial begin
        req0 = '0;
        req3 = '0;
        rst  = 1'b1;
        repeat (2) tick;

        // Reset state, with a live request that must not be granted
        drv0(1'b1, BASE, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("rst_gnt", rsp0.gnt, 1'b0);
        chk1("rst_rvalid", rsp0.r_valid, 1'b0);
        chk1("rst_err", err0, 1'b0);
        chk1("rst_busy", busy0, 1'b0);
        chk32("rst_rdata", rsp0.r_data, 32'h0);
        chk1("rst_busy3", busy3, 1'b0);
        drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        rst = 1'b0;
        tick;

        // Zero-wait: write then back-to-back read
        drv0(1'b1, BASE + 32'h8, 1'b1, 32'hDEADBEEF, 4'hF);
        settle;
        chk1("w0_gnt", rsp0.gnt, 1'b1);
        chk1("w0_busy_idle", busy0, 1'b0);
        tick;
        drv0(1'b1, BASE + 32'h8, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("r0_gnt", rsp0.gnt, 1'b1);
        chk1("w0_rvalid", rsp0.r_valid, 1'b1);
        chk32("w0_rdata", rsp0.r_data, 32'h0);
        chk1("w0_err", err0, 1'b0);
        chk1("w0_busy", busy0, 1'b1);
        tick;
        drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("idle_gnt", rsp0.gnt, 1'b0);
        chk1("r0_rvalid", rsp0.r_valid, 1'b1);
        chk32("r0_rdata", rsp0.r_data, 32'hDEADBEEF);
        tick;
        settle;
        chk1("r0_rvalid_off", rsp0.r_valid, 1'b0);
        chk32("r0_rdata_hold", rsp0.r_data, 32'hDEADBEEF);
        chk1("r0_busy_off", busy0, 1'b0);
        tick;

        // Partial byte write, readback with add[1:0] nonzero
        drv0(1'b1, BASE + 32'h8, 1'b1, 32'h0000_5500, 4'b0010);
        settle;
        chk1("pw_gnt", rsp0.gnt, 1'b1);
        tick;
        drv0(1'b1, BASE + 32'hB, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("pw_rvalid", rsp0.r_valid, 1'b1);
        tick;
        drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk32("pw_rdata", rsp0.r_data, 32'hDEAD55EF);
        tick;

        // Out-of-range read at the top bound, then an aliasing out-of-range write
        drv0(1'b1, BASE + 32'h400, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("oor_r_gnt", rsp0.gnt, 1'b1);
        tick;
        drv0(1'b1, BASE - 32'h3F8, 1'b1, 32'h1234_5678, 4'hF);
        settle;
        chk1("oor_r_rvalid", rsp0.r_valid, 1'b1);
        chk1("oor_r_err", err0, 1'b1);
        chk32("oor_r_rdata", rsp0.r_data, 32'hBADCAB1E);
        tick;
        drv0(1'b1, BASE + 32'h8, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("oor_w_err", err0, 1'b1);
        chk32("oor_w_rdata", rsp0.r_data, 32'h0);
        tick;
        drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("unch_err", err0, 1'b0);
        chk32("unch_rdata", rsp0.r_data, 32'hDEAD55EF);
        tick;
        settle;
        chk1("post_err", err0, 1'b0);
        chk1("post_rvalid", rsp0.r_valid, 1'b0);
        tick;

        // Three-wait write with req held
        drv3(1'b1, BASE + 32'h10, 1'b1, 32'hCAFEF00D, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            settle;
            chk1($sformatf("w3_gnt_c%0d", i), rsp3.gnt, (i == 4));
            chk1($sformatf("w3_busy_c%0d", i), busy3, (i > 1));
            tick;
        end
        drv3(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("w3_rvalid", rsp3.r_valid, 1'b1);
        chk32("w3_rdata", rsp3.r_data, 32'h0);
        chk1("w3_busy_c5", busy3, 1'b1);
        tick;
        settle;
        chk1("w3_busy_c6", busy3, 1'b0);

        // Three-wait read with req held
        drv3(1'b1, BASE + 32'h10, 1'b0, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            settle;
            chk1($sformatf("r3_gnt_c%0d", i), rsp3.gnt, (i == 4));
            chk1($sformatf("r3_busy_c%0d", i), busy3, (i > 1));
            chk1($sformatf("r3_rvalid_c%0d", i), rsp3.r_valid, 1'b0);
            tick;
        end
        drv3(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("r3_rvalid", rsp3.r_valid, 1'b1);
        chk32("r3_rdata", rsp3.r_data, 32'hCAFEF00D);
        chk1("r3_busy_c5", busy3, 1'b1);
        tick;
        settle;
        chk1("r3_rvalid_off", rsp3.r_valid, 1'b0);
        chk1("r3_busy_c6", busy3, 1'b0);
        tick;

        // Request dropped mid-wait: no grant, back to idle
        drv3(1'b1, BASE + 32'h14, 1'b0, 32'h0, 4'h0);
        for (int i = 1; i <= 2; i++) begin
            settle;
            chk1($sformatf("ab_gnt_c%0d", i), rsp3.gnt, 1'b0);
            tick;
        end
        drv3(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("ab_gnt_drop", rsp3.gnt, 1'b0);
        chk1("ab_busy_drop", busy3, 1'b1);
        tick;
        settle;
        chk1("ab_busy_idle", busy3, 1'b0);
        chk1("ab_rvalid", rsp3.r_valid, 1'b0);
        tick;

        // Granted write, reset during its response cycle
        drv3(1'b1, BASE + 32'h14, 1'b1, 32'h0BAD_F00D, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            settle;
            chk1($sformatf("rw_gnt_c%0d", i), rsp3.gnt, (i == 4));
            tick;
        end
        drv3(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("rw_rvalid_pre", rsp3.r_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rw_rvalid_rst", rsp3.r_valid, 1'b0);
        chk1("rw_busy_rst", busy3, 1'b0);
        chk32("rw_rdata_rst", rsp3.r_data, 32'h0);
        tick;
        rst = 1'b0;
        settle;
        chk1("rw_rvalid_rel", rsp3.r_valid, 1'b0);
        chk1("rw_busy_rel", busy3, 1'b0);
        chk1("rw_gnt_rel", rsp3.gnt, 1'b0);
        tick;
        settle;
        chk1("rw_rvalid_rel2", rsp3.r_valid, 1'b0);
        tick;

        // The reset-interrupted write stays committed
        drv3(1'b1, BASE + 32'h14, 1'b0, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            settle;
            chk1($sformatf("cm_gnt_c%0d", i), rsp3.gnt, (i == 4));
            tick;
        end
        drv3(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle;
        chk1("cm_rvalid", rsp3.r_valid, 1'b1);
        chk32("cm_rdata", rsp3.r_data, 32'h0BAD_F00D);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_data_responder.md
CORE_DATA_RESPONDER -- requirements
Module: core_data_responder

Interface
REQ-001 SHALL have parameter NumWords, default 256, meaning storage depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter WaitCycles, default 0, meaning grant delay in cycles that req is held high before gnt (0..15).
REQ-003 SHALL have parameter BaseAddr, default 32'h1000_0000, meaning byte address of word 0 (NumWords*4-aligned).
REQ-004 SHALL have parameter ErrData, default 32'hBADC_AB1E, meaning r_data returned for out-of-range reads.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is in this domain.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_i, input, core_data_req_t, carrying req, add, we, data and be from the core.
REQ-008 SHALL have port rsp_o, output, core_data_rsp_t, carrying gnt, r_data and r_valid to the core.
REQ-009 SHALL have port err_o, output, 1, pulsed high together with r_valid for an out-of-range access.
REQ-010 SHALL have port busy_o, output, 1, high while the FSM is not in IDLE.

Function
REQ-011 SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-012 The FSM SHALL go IDLE->WAIT on req when WaitCycles>0, and SHALL grant combinationally in IDLE when WaitCycles=0.
REQ-013 In WAIT, a 4-bit counter SHALL count cycles with req high; gnt SHALL assert in the cycle the count reaches WaitCycles.
REQ-014 If req drops in WAIT before gnt, the FSM SHALL return to IDLE, clear the counter and perform no access.
REQ-015 A handshake SHALL occur in a cycle with req=1 and gnt=1; add, we, data and be SHALL be sampled only in that cycle.
REQ-016 r_valid SHALL assert for exactly one cycle, exactly one cycle after each handshake (state RESP), for both reads and writes.
REQ-017 Read r_data SHALL be the addressed word as of the handshake edge; write r_data SHALL be 32'h0.
REQ-018 Writes SHALL update only the bytes whose be bit is set, committed at the handshake clock edge.
REQ-019 A read handshake in the cycle directly after a write to the same word SHALL return the new data.
REQ-020 In RESP with WaitCycles=0, a new request SHALL be granted in the same cycle as r_valid, giving full throughput of 1 access/cycle.
REQ-021 In RESP with WaitCycles>0, the FSM SHALL go to WAIT on req, else to IDLE.
REQ-022 Word index SHALL be (add - BaseAddr) >> 2; add[1:0] SHALL be ignored; the subtraction is 32-bit unsigned.
REQ-023 An access with add below BaseAddr or at/above BaseAddr+4*NumWords SHALL be out of range.
REQ-024 An out-of-range write SHALL leave storage unchanged; an out-of-range read SHALL return ErrData; both SHALL assert err_o with r_valid.
REQ-025 gnt SHALL never assert while req is low.
REQ-026 r_data SHALL hold its last value when r_valid is low.

Reset
REQ-027 While rst_i is high, the FSM SHALL be IDLE, the counter 0, and gnt, r_valid, err_o, busy_o and r_data all 0.
REQ-028 Storage contents SHALL not be reset.
REQ-029 Reset asserted mid-WAIT or mid-RESP SHALL abort the access with no r_valid after release; a write already granted stays committed.

Structure
REQ-030 SHALL import core_data_req_t and core_data_rsp_t from pulp_cluster_package, and the package SHALL gain a localparam holding the default ErrData.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 Storage SHALL be one sub-module, core_data_responder_mem: 1 read/write port, per-byte write enables, registered read.

Verification
REQ-033 WaitCycles=0: write add=BaseAddr+8, data=32'hDEADBEEF, be=4'hF, then read the same address back-to-back -> gnt on both request cycles; r_valid on the cycle after each; read r_data=32'hDEADBEEF.
REQ-034 Partial write of be=4'b0010 with data=32'h0000_5500 over word 32'hDEADBEEF, then read -> 32'hDEAD55EF.
REQ-035 WaitCycles=3: hold req on a read -> gnt in the 4th cycle of req; r_valid in the 5th cycle; busy_o high from the 2nd through the 5th cycle.
REQ-036 Read at add=BaseAddr+4*NumWords -> r_data=32'hBADCAB1E and err_o=1 with r_valid; storage unchanged.
REQ-037 WaitCycles=3: drop req after 2 cycles, then assert rst_i for 1 cycle during a later RESP -> no gnt for the aborted request; no r_valid after reset release; FSM in IDLE.
